bluetooth_send_result: RTL and testbench

UART 8N1 transmitter that returns the recognised digit to the Bluetooth module over the same serial link that delivers the picture, at the same baud rate. On a one-cycle `send` strobe from the classifier, it transmits a 3-byte ASCII message: the digit character, then CR, then LF. It sits beside the picture receiver at the top level, and its `tx` pin drives the Bluetooth module's RX line.

---
 rtl/bluetooth_send_result_pkg.sv | 34 +++
 rtl/bluetooth_send_result_uart_tx_byte.sv | 89 ++++++++
 rtl/bluetooth_send_result.sv | 87 ++++++++
 tb/tb_bluetooth_send_result.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bluetooth_send_result_pkg.sv
// Shared constants and types for the digit-report UART transmitter.
// Holds the bit timing, ASCII codes and FSM encodings.
package bluetooth_send_result_pkg;

  localparam int UART_BPS = 10417;
  localparam int MSG_LEN  = 3;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_FIN
  } seq_state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    logic [7:0] c;
    c = ASCII_QMARK;
    if (d <= 4'd9)
      c = ASCII_ZERO + {4'd0, d};
    return c;
  endfunction

endpackage

// File: rtl/bluetooth_send_result_uart_tx_byte.sv
// 8N1 byte serializer. A start request in the last stop-bit cycle
// chains the next byte with no idle gap between frames.
module uart_tx_byte
  import bluetooth_send_result_pkg::*;
#(
  parameter int BPS = UART_BPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BPS - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    sh;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);
  // High during the final cycle of the stop bit.
  assign ready   = (state == TX_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      if (state == TX_IDLE || bit_end)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      unique case (state)
        TX_IDLE: begin
          if (start) begin
            sh    <= data;
            tx    <= 1'b0;
            idx   <= 4'd0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx    <= sh[0];
            sh    <= {1'b0, sh[7:1]};
            idx   <= 4'd1;
            state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (idx == 4'd8) begin
              tx    <= 1'b1;
              idx   <= 4'd9;
              state <= TX_STOP;
            end else begin
              tx  <= sh[0];
              sh  <= {1'b0, sh[7:1]};
              idx <= idx + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (start) begin
              sh    <= data;
              tx    <= 1'b0;
              idx   <= 4'd0;
              state <= TX_START;
            end else begin
              idx   <= 4'd0;
              state <= TX_IDLE;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bluetooth_send_result.sv
// Sends the recognised digit as "<char>\r\n" over UART 8N1.
// Sequences three bytes through the serializer and flags completion.
module bluetooth_send_result
  import bluetooth_send_result_pkg::*;
#(
  parameter int BPS = UART_BPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [3:0] digit,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] LAST = 2'(MSG_LEN - 1);

  seq_state_t state;
  logic [1:0] byte_idx;
  logic       accept;
  logic       more;
  logic       ready;
  logic       start;
  logic [7:0] data;

  assign accept = (state == SEQ_IDLE) && send;
  assign more   = ready && (byte_idx < LAST);
  assign start  = accept || more;

  // The serializer captures data in the cycle start is high,
  // so the mapped digit is latched on acceptance.
  always_comb begin
    data = digit_char(digit);
    if (!accept)
      data = (byte_idx == 2'd0) ? ASCII_CR : ASCII_LF;
  end

  uart_tx_byte #(
    .BPS(BPS)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .tx   (tx),
    .ready(ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          done <= 1'b0;
          if (send) begin
            busy     <= 1'b1;
            byte_idx <= 2'd0;
            state    <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (ready) begin
            if (byte_idx < LAST) begin
              byte_idx <= byte_idx + 2'd1;
            end else begin
              byte_idx <= 2'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= SEQ_FIN;
            end
          end
        end
        SEQ_FIN: begin
          done  <= 1'b0;
          state <= SEQ_IDLE;
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bluetooth_send_result.sv
// Scoreboard bench: stimulus queues expected bytes and done pulses,
// negedge monitors decode tx and check framing and timing.
module tb_bluetooth_send_result;

  localparam int BPS   = 16;
  localparam int FRAME = 10 * BPS;
  localparam int MSG   = 3 * FRAME;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes[$];
  int         exp_done[$];

  bit gap_check = 0;
  int gaps = 0;

  bluetooth_send_result #(
    .BPS(BPS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .send (send),
    .digit(digit),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // UART decoder: checks every bit lasts BPS cycles and pops the
  // expected byte at the end of each stop bit.
  bit         d_active = 0;
  int         dc;
  logic       cur;
  logic       glitch;
  logic [9:0] bits;

  always @(negedge clk) begin
    if (rst) begin
      d_active = 0;
    end else begin
      if (!d_active && tx === 1'b0) begin
        d_active = 1;
        dc       = 0;
        glitch   = 0;
      end else if (d_active) begin
        dc++;
      end
      if (d_active) begin
        if (dc % BPS == 0)
          cur = tx;
        else if (tx !== cur)
          glitch = 1;
        if (dc % BPS == BPS / 2)
          bits[dc / BPS] = tx;
        if (dc == FRAME - 1) begin
          d_active = 0;
          check("frame", {glitch, bits[0], bits[9]}, 3'b001);
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte: got %02h, expected none", bits[8:1]);
          end else begin
            check("byte", bits[8:1], exp_bytes.pop_front());
          end
        end
      end
    end
  end

  // Busy/done monitor.
  int   cyc = 0;
  int   bcnt = 0;
  int   done_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bcnt      = 0;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy === 1'b1 && !prev_busy && gap_check) begin
        check("gap", cyc - done_cyc, 2);
        gaps++;
      end
      if (busy === 1'b1)
        bcnt++;
      if (prev_done)
        check("done_width", done, 0);
      if (done === 1'b1) begin
        check("done_state", {busy, tx}, 2'b01);
        check("busy_len", bcnt, MSG);
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done: got pulse, expected none");
        end else begin
          void'(exp_done.pop_front());
        end
        bcnt     = 0;
        done_cyc = cyc;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic push_msg(input logic [7:0] ch);
    exp_bytes.push_back(ch);
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
    exp_done.push_back(1);
  endtask

  task automatic send_msg(input logic [3:0] d, input logic [7:0] ch);
    push_msg(ch);
    @(posedge clk);
    #1;
    send  = 1'b1;
    digit = d;
    check("pre_start", tx, 1'b1);
    @(posedge clk);
    #1;
    send  = 1'b0;
    digit = 4'($urandom);
    check("latency", {tx, busy}, 2'b01);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_done.size() != 0 ||
            busy !== 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("timeout", n < 4000, 1'b1);
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_send(input logic [3:0] d);
    @(posedge clk);
    #1;
    send  = 1'b1;
    digit = d;
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", {tx, busy, done}, 3'b100);

    ok = 1;
    repeat (100) begin
      @(negedge clk);
      if ({tx, busy, done} !== 3'b100)
        ok = 0;
    end
    check("idle", ok, 1'b1);

    send_msg(4'd7, 8'h37);
    wait_idle();

    send_msg(4'd12, 8'h3F);
    wait_idle();
    send_msg(4'd0, 8'h30);
    wait_idle();
    send_msg(4'd9, 8'h39);
    wait_idle();

    send_msg(4'd5, 8'h35);
    repeat (48) @(posedge clk);
    pulse_send(4'd3);
    repeat (248) @(posedge clk);
    pulse_send(4'd3);
    wait_idle();

    push_msg(8'h31);
    push_msg(8'h31);
    @(posedge clk);
    #1;
    send  = 1'b1;
    digit = 4'd1;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done", n < 2000, 1'b1);
    gap_check = 1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_restart", n < 20, 1'b1);
    @(posedge clk);
    #1;
    send = 1'b0;
    wait_idle();
    gap_check = 0;
    check("gap_seen", gaps, 1);

    send_msg(4'd8, 8'h38);
    repeat (199) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_tx", {tx, busy, done}, 3'b100);
    rst = 1'b0;
    exp_bytes.delete();
    exp_done.delete();
    repeat (600) @(posedge clk);
    #1;
    check("abort_idle", {tx, busy, done}, 3'b100);

    send_msg(4'd4, 8'h34);
    wait_idle();

    check("leftover", exp_bytes.size() + exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
